sip_dot_acc: RTL and testbench

Multi-cycle, precision-reconfigurable dot-product engine for the BitBlade datapath. Each accepted beat carries one 2-bit activation slice and one 2-bit weight slice per lane. Per beat the block forms N_DOT signed 3x3 products, reduces them in a registered adder tree, and shift-accumulates the result across all slice pairs of one operation. It emits one signed result per operation over a valid/ready handshake, sitting between the slice-feeding buffer and the output/requantiser stage.

---
 rtl/sip_dot_acc_pkg.sv | 30 +++
 rtl/sip_dot_tree.sv | 46 ++++
 rtl/sip_dot_acc.sv | 193 +++++++++++++++++++
 tb/tb_sip_dot_acc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sip_dot_acc_pkg.sv
// ============================================================================
// sip_dot_acc_pkg : shared constants, state encoding and clog2 helper
// Rev 1.0
// ============================================================================
`default_nettype none

package sip_dot_acc_pkg;

  localparam int BITS_PARALLEL = 2;
  localparam int PROD_W        = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sip_dot_tree.sv
// ============================================================================
// sip_dot_tree : N_DOT signed 3x3 lane multipliers feeding a pairwise adder tree
// Rev 1.0
// ============================================================================
`default_nettype none

module sip_dot_tree
  import sip_dot_acc_pkg::*;
#(
  parameter int N_DOT = 8,
  parameter int SUM_W = PROD_W + clog2(N_DOT)
) (
  input  logic [N_DOT*BITS_PARALLEL-1:0] i_Act,
  input  logic [N_DOT*BITS_PARALLEL-1:0] i_Weight,
  input  logic                           i_ExtA,
  input  logic                           i_ExtW,
  output logic signed [SUM_W-1:0]        o_Sum
);

  logic signed [PROD_W-1:0] w_prod [N_DOT];

  for (genvar l = 0; l < N_DOT; l++) begin : g_lane
    logic signed [2:0] w_a;
    logic signed [2:0] w_w;
    // The extension bit is the slice MSB only for the top slice of a signed operand.
    assign w_a = {i_ExtA & i_Act[l*BITS_PARALLEL+1],    i_Act[l*BITS_PARALLEL +: BITS_PARALLEL]};
    assign w_w = {i_ExtW & i_Weight[l*BITS_PARALLEL+1], i_Weight[l*BITS_PARALLEL +: BITS_PARALLEL]};
    assign w_prod[l] = PROD_W'(w_a) * PROD_W'(w_w);
  end

  always_comb begin : p_tree
    logic signed [SUM_W-1:0] w_node [N_DOT];
    for (int l = 0; l < N_DOT; l++) begin
      w_node[l] = SUM_W'(w_prod[l]);
    end
    for (int s = 1; s < N_DOT; s = s * 2) begin
      for (int k = 0; k < N_DOT; k = k + 2 * s) begin
        w_node[k] = w_node[k] + w_node[k+s];
      end
    end
    o_Sum = w_node[0];
  end

endmodule

`default_nettype wire

// File: rtl/sip_dot_acc.sv
// ============================================================================
// sip_dot_acc : slice-serial signed dot-product engine with shift-accumulate.
// Optional SIP_ACC_SATURATE_EN: saturating (sticky) accumulator. Rev 1.0
// ============================================================================
`default_nettype none

module sip_dot_acc
  import sip_dot_acc_pkg::*;
#(
  parameter int N_DOT      = 8,
  parameter int MAX_SLICES = 4,
  parameter int BITS_ACC   = 32
) (
  input  logic                           i_CLK,
  input  logic                           i_RSTn,
  input  logic                           i_Valid,
  output logic                           o_Ready,
  input  logic [N_DOT*BITS_PARALLEL-1:0] i_Act,
  input  logic [N_DOT*BITS_PARALLEL-1:0] i_Weight,
  input  logic                           i_SignI,
  input  logic                           i_SignW,
  input  logic [clog2(MAX_SLICES)-1:0]   i_NSliceA,
  input  logic [clog2(MAX_SLICES)-1:0]   i_NSliceW,
  output logic                           o_Valid,
  input  logic                           i_Ready,
  output logic [BITS_ACC-1:0]            o_Result
);

  localparam int CNT_W = clog2(MAX_SLICES);
  localparam int SUM_W = PROD_W + clog2(N_DOT);
  localparam int SH_W  = CNT_W + 2;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_ia, r_iw, r_nsa, r_nsw;
  logic                    r_sign_i, r_sign_w;
  logic [CNT_W-1:0]        w_nsa, w_nsw;
  logic                    w_sign_i, w_sign_w;
  logic                    w_idle, w_accept, w_last_a, w_last_w, w_last;
  logic signed [SUM_W-1:0] w_sum;

  logic                    r_s1_vld, r_s1_first, r_s1_last;
  logic signed [SUM_W-1:0] r_s1_sum;
  logic [SH_W-1:0]         r_s1_shift;

  logic signed [BITS_ACC-1:0] r_acc, w_acc_nxt, w_base;

  assign w_idle   = (r_state == ST_IDLE);
  assign o_Ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign o_Valid  = (r_state == ST_DONE);
  assign o_Result = r_acc;
  assign w_accept = i_Valid && o_Ready;

  // The first beat uses the live mode inputs; later beats use the latched copy.
  assign w_nsa    = w_idle ? i_NSliceA : r_nsa;
  assign w_nsw    = w_idle ? i_NSliceW : r_nsw;
  assign w_sign_i = w_idle ? i_SignI   : r_sign_i;
  assign w_sign_w = w_idle ? i_SignW   : r_sign_w;
  assign w_last_a = (r_ia == w_nsa);
  assign w_last_w = (r_iw == w_nsw);
  assign w_last   = w_last_a && w_last_w;

  sip_dot_tree #(
    .N_DOT (N_DOT),
    .SUM_W (SUM_W)
  ) u_tree (
    .i_Act    (i_Act),
    .i_Weight (i_Weight),
    .i_ExtA   (w_sign_i && w_last_a),
    .i_ExtW   (w_sign_w && w_last_w),
    .o_Sum    (w_sum)
  );

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state  <= ST_IDLE;
      r_ia     <= '0;
      r_iw     <= '0;
      r_nsa    <= '0;
      r_nsw    <= '0;
      r_sign_i <= 1'b0;
      r_sign_w <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_idle) begin
        r_nsa    <= i_NSliceA;
        r_nsw    <= i_NSliceW;
        r_sign_i <= i_SignI;
        r_sign_w <= i_SignW;
      end
      if (w_accept) begin
        if (w_last_a) begin
          r_ia <= '0;
          r_iw <= w_last_w ? '0 : r_iw + 1'b1;
        end else begin
          r_ia <= r_ia + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_accept) begin
          w_state_nxt = w_last ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (r_s1_vld && r_s1_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_Ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_sum   <= w_sum;
        r_s1_shift <= SH_W'({r_ia, 1'b0}) + SH_W'({r_iw, 1'b0});
        r_s1_first <= w_idle;
        r_s1_last  <= w_last;
      end
    end
  end

  assign w_base = r_s1_first ? '0 : r_acc;

`ifdef SIP_ACC_SATURATE_EN
  localparam int WIDE_W = BITS_ACC + SUM_W + 4 * MAX_SLICES;
  localparam logic signed [WIDE_W-1:0] c_MAX = {{(WIDE_W-BITS_ACC+1){1'b0}}, {(BITS_ACC-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] c_MIN = {{(WIDE_W-BITS_ACC+1){1'b1}}, {(BITS_ACC-1){1'b0}}};

  logic                     r_sat, w_sat_nxt;
  logic signed [WIDE_W-1:0] w_wide;

  assign w_wide = WIDE_W'(w_base) + (WIDE_W'(r_s1_sum) <<< r_s1_shift);

  // Once an operation clips, it stays clipped until the next first beat.
  always_comb begin
    w_acc_nxt = w_wide[BITS_ACC-1:0];
    w_sat_nxt = 1'b0;
    if (r_sat && !r_s1_first) begin
      w_acc_nxt = r_acc;
      w_sat_nxt = 1'b1;
    end else if (w_wide > c_MAX) begin
      w_acc_nxt = c_MAX[BITS_ACC-1:0];
      w_sat_nxt = 1'b1;
    end else if (w_wide < c_MIN) begin
      w_acc_nxt = c_MIN[BITS_ACC-1:0];
      w_sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_sat <= 1'b0;
    end else if (r_s1_vld) begin
      r_sat <= w_sat_nxt;
    end
  end
`else
  logic signed [BITS_ACC-1:0] w_addend;

  assign w_addend  = BITS_ACC'(r_s1_sum) <<< r_s1_shift;
  assign w_acc_nxt = w_base + w_addend;
`endif

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_acc <= '0;
    end else if (r_s1_vld) begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sip_dot_acc.sv
// ============================================================================
// tb_sip_dot_acc : randomized self-checking bench for sip_dot_acc (32- and 12-bit acc)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sip_dot_acc;

  localparam int N = 8;
  localparam int W = 2 * N;

  logic         i_CLK = 1'b0;
  logic         i_RSTn = 1'b0;
  logic         i_Valid = 1'b0;
  logic         i_Ready = 1'b0;
  logic         i_SignI = 1'b0;
  logic         i_SignW = 1'b0;
  logic [W-1:0] i_Act = '0;
  logic [W-1:0] i_Weight = '0;
  logic [1:0]   i_NSliceA = '0;
  logic [1:0]   i_NSliceW = '0;
  logic         o_Ready, o_Valid, o_Ready12, o_Valid12;
  logic [31:0]  o_Result;
  logic [11:0]  o_Result12;

  int n_tests = 0;
  int n_fail  = 0;
  int act [N];
  int wgt [N];

  always #5 i_CLK = ~i_CLK;

  sip_dot_acc #(.N_DOT(N), .MAX_SLICES(4), .BITS_ACC(32)) u_dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Act(i_Act), .i_Weight(i_Weight), .i_SignI(i_SignI), .i_SignW(i_SignW),
    .i_NSliceA(i_NSliceA), .i_NSliceW(i_NSliceW), .o_Valid(o_Valid),
    .i_Ready(i_Ready), .o_Result(o_Result)
  );

  sip_dot_acc #(.N_DOT(N), .MAX_SLICES(4), .BITS_ACC(12)) u_dut12 (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_Valid(i_Valid), .o_Ready(o_Ready12),
    .i_Act(i_Act), .i_Weight(i_Weight), .i_SignI(i_SignI), .i_SignW(i_SignW),
    .i_NSliceA(i_NSliceA), .i_NSliceW(i_NSliceW), .o_Valid(o_Valid12),
    .i_Ready(i_Ready), .o_Result(o_Result12)
  );

  function automatic int slice(input int v, input int k, input bit sx);
    int s;
    s = (v >>> (2 * k)) & 3;
    if (sx && s >= 2) s = s - 4;
    return s;
  endfunction

  function automatic int rand_operand(input int ns, input bit sgn);
    int bits;
    bits = 2 * (ns + 1);
    if (sgn) return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
    return int'($urandom_range(0, (1 << bits) - 1));
  endfunction

  // Expected 12-bit result: saturating walk over slice pairs, or plain wrap of the exact value.
  function automatic longint model12(input int nsa, input int nsw, input bit si, input bit sw);
    longint acc;
`ifdef SIP_ACC_SATURATE_EN
    longint part;
    bit     sat;
    acc = 0;
    sat = 0;
    for (int iw = 0; iw <= nsw; iw++) begin
      for (int ia = 0; ia <= nsa; ia++) begin
        part = 0;
        for (int l = 0; l < N; l++) begin
          part += longint'(slice(act[l], ia, si && ia == nsa)) * longint'(slice(wgt[l], iw, sw && iw == nsw));
        end
        part = part * (longint'(1) << (2 * (ia + iw)));
        if (!sat) begin
          acc += part;
          if (acc > 2047) begin acc = 2047; sat = 1; end
          else if (acc < -2048) begin acc = -2048; sat = 1; end
        end
      end
    end
`else
    acc = 0;
    for (int l = 0; l < N; l++) acc += longint'(act[l]) * longint'(wgt[l]);
    acc = acc & 64'hFFF;
    if (acc >= 2048) acc = acc - 4096;
`endif
    return acc;
  endfunction

  task automatic run_op(input int nsa, input int nsw, input bit si, input bit sw, input int hold,
                        input bit bubbles, output longint res32, output longint res12);
    longint       exact, e12;
    int           lat;
    logic [31:0]  held;
    logic [W-1:0] va, vw;
    bit           first;
    exact = 0;
    for (int l = 0; l < N; l++) exact += longint'(act[l]) * longint'(wgt[l]);
    e12   = model12(nsa, nsw, si, sw);
    first = 1;
    for (int iw = 0; iw <= nsw; iw++) begin
      for (int ia = 0; ia <= nsa; ia++) begin
        if (bubbles && !first) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge i_CLK);
            i_Valid = 0; i_Act = W'($urandom); i_Weight = W'($urandom);
            i_NSliceA = 2'($urandom); i_SignI = 1'($urandom);
          end
        end
        for (int l = 0; l < N; l++) begin
          va[2*l +: 2] = 2'(slice(act[l], ia, 1'b0));
          vw[2*l +: 2] = 2'(slice(wgt[l], iw, 1'b0));
        end
        @(negedge i_CLK);
        n_tests++;
        if (o_Ready !== 1'b1) begin
          n_fail++;
          $display("FAIL beat_ready: o_Ready=%b expected 1 (iw=%0d ia=%0d)", o_Ready, iw, ia);
        end
        i_Valid = 1; i_Act = va; i_Weight = vw; i_Ready = 1'($urandom);
        if (first) begin
          i_NSliceA = 2'(nsa); i_NSliceW = 2'(nsw); i_SignI = si; i_SignW = sw;
        end else begin
          i_NSliceA = 2'($urandom); i_NSliceW = 2'($urandom);
          i_SignI = 1'($urandom); i_SignW = 1'($urandom);
        end
        first = 0;
        @(posedge i_CLK);
      end
    end
    lat = 0;
    do begin
      @(negedge i_CLK);
      i_Valid = 0; i_Ready = 0; lat++;
    end while (o_Valid !== 1'b1 && lat < 20);
    n_tests++;
    if (lat != 2 || o_Valid !== 1'b1 || o_Valid12 !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: %0d cycles valid=%b/%b, expected 2 cycles valid=1", lat, o_Valid, o_Valid12);
    end
    n_tests++;
    if (longint'($signed(o_Result)) !== exact) begin
      n_fail++;
      $display("FAIL result32: got %0d expected %0d", $signed(o_Result), exact);
    end
    n_tests++;
    if (longint'($signed(o_Result12)) !== e12) begin
      n_fail++;
      $display("FAIL result12: got %0d expected %0d", $signed(o_Result12), e12);
    end
    n_tests++;
    if (o_Ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ready: o_Ready=%b expected 0", o_Ready);
    end
    res32 = longint'($signed(o_Result));
    res12 = longint'($signed(o_Result12));
    held  = o_Result;
    for (int h = 0; h < hold; h++) begin
      i_Valid = 1; i_Act = W'($urandom); i_Weight = W'($urandom);
      @(negedge i_CLK);
      n_tests++;
      if (o_Valid !== 1'b1 || o_Ready !== 1'b0 || o_Result !== held) begin
        n_fail++;
        $display("FAIL backpressure: valid=%b ready=%b result=%h expected 1 0 %h", o_Valid, o_Ready, o_Result, held);
      end
    end
    i_Valid = 0; i_Ready = 1;
    @(negedge i_CLK);
    i_Ready = 0;
    n_tests++;
    if (o_Valid !== 1'b0 || o_Valid12 !== 1'b0 || o_Ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release: valid=%b/%b ready=%b expected 0/0 1", o_Valid, o_Valid12, o_Ready);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_tests++;
    if (o_Ready !== 1'b1 || o_Valid !== 1'b0 || o_Result !== 32'd0 ||
        o_Ready12 !== 1'b1 || o_Valid12 !== 1'b0 || o_Result12 !== 12'd0) begin
      n_fail++;
      $display("FAIL %s: ready=%b valid=%b result=%h r12=%h expected 1 0 0 0", nm, o_Ready, o_Valid, o_Result, o_Result12);
    end
  endtask

  task automatic test_reset();
    i_RSTn = 0;
    repeat (2) @(negedge i_CLK);
    check_reset_outputs("reset_state");
    i_RSTn = 1;
    @(negedge i_CLK);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_unsigned_2b();
    longint r32, r12;
    for (int l = 0; l < N; l++) begin act[l] = 3; wgt[l] = 3; end
    run_op(0, 0, 0, 0, 0, 0, r32, r12);
    n_tests++;
    if (r32 !== 72) begin n_fail++; $display("FAIL unsigned_2b: got %0d expected 72", r32); end
  endtask

  task automatic test_signed_4b();
    longint r32, r12;
    for (int l = 0; l < N; l++) begin act[l] = -8; wgt[l] = 7; end
    run_op(1, 1, 1, 1, 0, 0, r32, r12);
    n_tests++;
    if (r32 !== -448) begin n_fail++; $display("FAIL signed_4b: got %0d expected -448", r32); end
  endtask

  task automatic test_mixed();
    longint r32, r12;
    for (int l = 0; l < N; l++) begin act[l] = 0; wgt[l] = 0; end
    act[0] = 200; wgt[0] = -1;
    run_op(3, 0, 0, 1, 0, 1, r32, r12);
    n_tests++;
    if (r32 !== -200) begin n_fail++; $display("FAIL mixed: got %0d expected -200", r32); end
  endtask

  task automatic test_backpressure();
    longint r32, r12;
    for (int l = 0; l < N; l++) begin act[l] = rand_operand(1, 1); wgt[l] = rand_operand(1, 0); end
    run_op(1, 1, 1, 0, 3, 0, r32, r12);
  endtask

  task automatic test_overflow12();
    longint r32, r12, e;
    for (int l = 0; l < N; l++) begin act[l] = 255; wgt[l] = 255; end
    run_op(3, 3, 0, 0, 0, 0, r32, r12);
`ifdef SIP_ACC_SATURATE_EN
    e = 2047;
`else
    e = 8;
`endif
    n_tests++;
    if (r12 !== e || r32 !== 520200) begin
      n_fail++;
      $display("FAIL overflow12: got %0d/%0d expected %0d/520200", r12, r32, e);
    end
  endtask

  task automatic test_mid_reset();
    longint r32, r12;
    for (int l = 0; l < N; l++) begin act[l] = 0; wgt[l] = 0; end
    act[0] = 3; wgt[0] = 3;
    for (int b = 0; b < 2; b++) begin
      @(negedge i_CLK);
      i_Valid = 1; i_NSliceA = 2'd3; i_NSliceW = 2'd3; i_SignI = 0; i_SignW = 0;
      i_Act = '1; i_Weight = '1;
      @(posedge i_CLK);
    end
    @(negedge i_CLK);
    i_Valid = 0;
    i_RSTn  = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge i_CLK);
    i_RSTn = 1;
    for (int l = 0; l < N; l++) begin act[l] = rand_operand(0, 0); wgt[l] = rand_operand(0, 0); end
    run_op(0, 0, 0, 0, 0, 0, r32, r12);
  endtask

  task automatic test_random();
    longint r32, r12;
    int     nsa, nsw;
    bit     si, sw;
    for (int t = 0; t < 30; t++) begin
      nsa = $urandom_range(0, 3); nsw = $urandom_range(0, 3);
      si = 1'($urandom); sw = 1'($urandom);
      for (int l = 0; l < N; l++) begin act[l] = rand_operand(nsa, si); wgt[l] = rand_operand(nsw, sw); end
      run_op(nsa, nsw, si, sw, $urandom_range(0, 2), 1, r32, r12);
    end
  endtask

  task automatic test_back_to_back();
    longint r32, r12;
    for (int t = 0; t < 4; t++) begin
      for (int l = 0; l < N; l++) begin act[l] = rand_operand(3, 1); wgt[l] = rand_operand(3, 1); end
      run_op(3, 3, 1, 1, 0, 0, r32, r12);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_2b();
    test_signed_4b();
    test_mixed();
    test_backpressure();
    test_overflow12();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
